// File: rtl/conv_addr_seq.sv
// Convolution loop-nest sequencer: walks co/orow/ocol/ci/kr/kc and emits one
// input/weight/output BRAM address triple per accepted step.
module conv_addr_seq #(
    parameter int AW   = 13,
    parameter int DIMW = 13,
    parameter int SW   = 3,
    parameter int PW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [DIMW-1:0] do_ch,
    input  logic [DIMW-1:0] di,
    input  logic [DIMW-1:0] dr,
    input  logic [DIMW-1:0] dc,
    input  logic [DIMW-1:0] dkr,
    input  logic [DIMW-1:0] dkc,
    input  logic [DIMW-1:0] dr_out,
    input  logic [DIMW-1:0] dc_out,
    input  logic [SW-1:0]   stride,
    input  logic [PW-1:0]   pad,
    input  logic [AW-1:0]   inaddr,
    input  logic [AW-1:0]   waddr,
    input  logic [AW-1:0]   outaddr,
    output logic            step_valid,
    input  logic            step_ready,
    output logic [AW-1:0]   in_addr,
    output logic [AW-1:0]   w_addr,
    output logic [AW-1:0]   out_addr,
    output logic            pad_zero,
    output logic            first,
    output logic            last,
    output logic            busy,
    output logic            done,
    output logic            cfg_err
);

    localparam int TW = DIMW + 2;

    typedef enum logic [1:0] {IDLE, CHK, RUN, DONE} state_t;
    state_t state, state_n;

    logic            mode_q;
    logic [DIMW-1:0] do_q, di_q, dr_q, dc_q, dkr_q, dkc_q, dro_q, dco_q;
    logic [SW-1:0]   stride_q;
    logic [PW-1:0]   pad_q;
    logic [AW-1:0]   inb_q, wb_q, outb_q;

    logic [DIMW-1:0] co, orow, ocol, ci, kr, kc;
    logic [DIMW-1:0] co_n, orow_n, ocol_n, ci_n, kr_n, kc_n;

    logic cfg_bad, accept, final_step;
    logic kc_wrap, kr_wrap, ci_wrap, ocol_wrap, orow_wrap, co_wrap;

    // Padded extents for the kernel-fits check
    logic [TW-1:0] ext_r, ext_c;
    assign ext_r = TW'(dr_q) + TW'(pad_q) + TW'(pad_q);
    assign ext_c = TW'(dc_q) + TW'(pad_q) + TW'(pad_q);

    assign cfg_bad = (do_q == '0) || (di_q == '0) || (dr_q == '0) || (dc_q == '0) ||
                     (dkr_q == '0) || (dkc_q == '0) || (dro_q == '0) || (dco_q == '0) ||
                     (stride_q == '0) || (mode_q && (di_q != do_q)) ||
                     (TW'(dkr_q) > ext_r) || (TW'(dkc_q) > ext_c);

    assign accept    = (state == RUN) && step_valid && step_ready;
    assign kc_wrap   = (kc == dkc_q - 1'b1);
    assign kr_wrap   = (kr == dkr_q - 1'b1);
    assign ci_wrap   = mode_q || (ci == di_q - 1'b1);
    assign ocol_wrap = (ocol == dco_q - 1'b1);
    assign orow_wrap = (orow == dro_q - 1'b1);
    assign co_wrap   = (co == do_q - 1'b1);
    assign final_step = kc_wrap && kr_wrap && ci_wrap && ocol_wrap && orow_wrap && co_wrap;

    // Counter odometer, innermost kc first
    always_comb begin
        co_n   = co;
        orow_n = orow;
        ocol_n = ocol;
        ci_n   = ci;
        kr_n   = kr;
        kc_n   = kc;
        if (state == CHK) begin
            co_n = '0; orow_n = '0; ocol_n = '0; ci_n = '0; kr_n = '0; kc_n = '0;
        end else if (accept && !final_step) begin
            if (!kc_wrap) kc_n = kc + 1'b1;
            else begin
                kc_n = '0;
                if (!kr_wrap) kr_n = kr + 1'b1;
                else begin
                    kr_n = '0;
                    if (!ci_wrap) ci_n = ci + 1'b1;
                    else begin
                        ci_n = '0;
                        if (!ocol_wrap) ocol_n = ocol + 1'b1;
                        else begin
                            ocol_n = '0;
                            if (!orow_wrap) orow_n = orow + 1'b1;
                            else begin
                                orow_n = '0;
                                co_n   = co + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CHK;
            CHK:     state_n = cfg_bad ? DONE : RUN;
            RUN:     if (accept && final_step) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address datapath evaluated on the next-step counters so outputs can be registered
    logic [DIMW-1:0] ci_e;
    logic [TW-1:0]   r_u, c_u;
    logic            tap_out;
    logic [AW-1:0]   in_nxt, w_nxt, out_nxt;
    logic            first_nxt, last_nxt;

    always_comb begin
        ci_e    = mode_q ? co_n : ci_n;
        r_u     = TW'(orow_n) * TW'(stride_q) + TW'(kr_n) - TW'(pad_q);
        c_u     = TW'(ocol_n) * TW'(stride_q) + TW'(kc_n) - TW'(pad_q);
        tap_out = ($signed(r_u) < 0) || ($signed(r_u) >= $signed(TW'(dr_q))) ||
                  ($signed(c_u) < 0) || ($signed(c_u) >= $signed(TW'(dc_q)));
        in_nxt  = tap_out ? '0 :
                  inb_q + (AW'(ci_e) * AW'(dr_q) + AW'(r_u)) * AW'(dc_q) + AW'(c_u);
        if (mode_q)
            w_nxt = wb_q + (AW'(co_n) * AW'(dkr_q) + AW'(kr_n)) * AW'(dkc_q) + AW'(kc_n);
        else
            w_nxt = wb_q + ((AW'(co_n) * AW'(di_q) + AW'(ci_n)) * AW'(dkr_q) + AW'(kr_n))
                    * AW'(dkc_q) + AW'(kc_n);
        out_nxt   = outb_q + (AW'(co_n) * AW'(dro_q) + AW'(orow_n)) * AW'(dco_q) + AW'(ocol_n);
        first_nxt = (mode_q || (ci_n == '0)) && (kr_n == '0) && (kc_n == '0);
        last_nxt  = (mode_q || (ci_n == di_q - 1'b1)) && (kr_n == dkr_q - 1'b1) &&
                    (kc_n == dkc_q - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            co <= '0; orow <= '0; ocol <= '0; ci <= '0; kr <= '0; kc <= '0;
        end else begin
            state <= state_n;
            co <= co_n; orow <= orow_n; ocol <= ocol_n;
            ci <= ci_n; kr <= kr_n; kc <= kc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            do_q <= '0; di_q <= '0; dr_q <= '0; dc_q <= '0;
            dkr_q <= '0; dkc_q <= '0; dro_q <= '0; dco_q <= '0;
            stride_q <= '0; pad_q <= '0;
            inb_q <= '0; wb_q <= '0; outb_q <= '0;
        end else if (state == IDLE && start) begin
            mode_q <= mode;
            do_q <= do_ch; di_q <= di; dr_q <= dr; dc_q <= dc;
            dkr_q <= dkr; dkc_q <= dkc; dro_q <= dr_out; dco_q <= dc_out;
            stride_q <= stride; pad_q <= pad;
            inb_q <= inaddr; wb_q <= waddr; outb_q <= outaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_valid <= 1'b0;
            in_addr    <= '0;
            w_addr     <= '0;
            out_addr   <= '0;
            pad_zero   <= 1'b0;
            first      <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    cfg_err <= 1'b0;
                end
                CHK: if (cfg_bad) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    cfg_err <= 1'b1;
                end else begin
                    step_valid <= 1'b1;
                    in_addr    <= in_nxt;
                    w_addr     <= w_nxt;
                    out_addr   <= out_nxt;
                    pad_zero   <= tap_out;
                    first      <= first_nxt;
                    last       <= last_nxt;
                end
                RUN: if (accept) begin
                    if (final_step) begin
                        step_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        in_addr  <= in_nxt;
                        w_addr   <= w_nxt;
                        out_addr <= out_nxt;
                        pad_zero <= tap_out;
                        first    <= first_nxt;
                        last     <= last_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Directed bench for conv_addr_seq: a loop-nest reference model fills a queue of
// expected steps, each accepted DUT step is popped and compared.
module tb_conv_addr_seq;

    localparam int AW = 13, DIMW = 13;

    logic            clk = 1'b0;
    logic            rst, start, mode, step_ready;
    logic [DIMW-1:0] do_ch, di, dr, dc, dkr, dkc, dr_out, dc_out;
    logic [2:0]      stride, pad;
    logic [AW-1:0]   inaddr, waddr, outaddr;
    logic            step_valid, pad_zero, first, last, busy, done, cfg_err;
    logic [AW-1:0]   in_addr, w_addr, out_addr;

    conv_addr_seq #(.AW(AW), .DIMW(DIMW), .SW(3), .PW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .do_ch(do_ch), .di(di), .dr(dr), .dc(dc), .dkr(dkr), .dkc(dkc),
        .dr_out(dr_out), .dc_out(dc_out), .stride(stride), .pad(pad),
        .inaddr(inaddr), .waddr(waddr), .outaddr(outaddr),
        .step_valid(step_valid), .step_ready(step_ready),
        .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
        .pad_zero(pad_zero), .first(first), .last(last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int c_mode, c_do, c_di, c_dr, c_dc, c_kr, c_kc, c_dro, c_dco, c_st, c_pad;
    logic [41:0] exp_q[$];
    logic [41:0] obs[$];
    int exp_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int m, input int o, input int i, input int r, input int c,
                           input int k, input int ro, input int co, input int s, input int p);
        c_mode = m; c_do = o; c_di = i; c_dr = r; c_dc = c; c_kr = k; c_kc = k;
        c_dro = ro; c_dco = co; c_st = s; c_pad = p;
    endtask

    task automatic apply_cfg();
        mode = c_mode[0]; do_ch = DIMW'(c_do); di = DIMW'(c_di); dr = DIMW'(c_dr);
        dc = DIMW'(c_dc); dkr = DIMW'(c_kr); dkc = DIMW'(c_kc);
        dr_out = DIMW'(c_dro); dc_out = DIMW'(c_dco);
        stride = 3'(c_st); pad = 3'(c_pad);
        inaddr = 13'd1000; waddr = 13'd2000; outaddr = 13'd3000;
    endtask

    task automatic junk_cfg();
        mode = 1'($urandom); do_ch = DIMW'($urandom); di = DIMW'($urandom);
        dr = DIMW'($urandom); dc = DIMW'($urandom); dkr = '0; dkc = DIMW'($urandom);
        dr_out = DIMW'($urandom); dc_out = DIMW'($urandom); stride = '0; pad = 3'($urandom);
        inaddr = AW'($urandom); waddr = AW'($urandom); outaddr = AW'($urandom);
    endtask

    // Straight loop-nest reference, formulas taken directly from the address equations
    task automatic gen_expected();
        int nci, cie, r, c, ia, wa, oa;
        bit pz, f, l;
        exp_q.delete();
        nci = c_mode ? 1 : c_di;
        for (int co = 0; co < c_do; co++)
          for (int orow = 0; orow < c_dro; orow++)
            for (int ocol = 0; ocol < c_dco; ocol++)
              for (int ci = 0; ci < nci; ci++)
                for (int kr = 0; kr < c_kr; kr++)
                  for (int kc = 0; kc < c_kc; kc++) begin
                      cie = c_mode ? co : ci;
                      r = orow * c_st + kr - c_pad;
                      c = ocol * c_st + kc - c_pad;
                      pz = (r < 0) || (r >= c_dr) || (c < 0) || (c >= c_dc);
                      ia = pz ? 0 : (1000 + (cie * c_dr + r) * c_dc + c);
                      wa = c_mode ? (2000 + (co * c_kr + kr) * c_kc + kc)
                                  : (2000 + ((co * c_di + ci) * c_kr + kr) * c_kc + kc);
                      oa = 3000 + (co * c_dro + orow) * c_dco + ocol;
                      f = (ci == 0) && (kr == 0) && (kc == 0);
                      l = (c_mode != 0 || ci == c_di - 1) && (kr == c_kr - 1) && (kc == c_kc - 1);
                      exp_q.push_back({ia[12:0], wa[12:0], oa[12:0], pz, f, l});
                  end
        exp_total = exp_q.size();
    endtask

    task automatic run(input string name, input bit exp_err, input int drop_at,
                       input int abort_at, input bit poke);
        int cyc, last_acc, nacc;
        bit stalled, finished;
        logic [42:0] v, snap;
        obs.delete();
        if (exp_err) begin exp_q.delete(); exp_total = 0; end
        else gen_expected();
        @(negedge clk);
        apply_cfg();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy_after_start"}, busy, 1);
        check({name, ".cfg_err_cleared"}, cfg_err, 0);
        check({name, ".no_valid_in_chk"}, step_valid, 0);
        junk_cfg();
        last_acc = -10; nacc = 0; stalled = 0; finished = 0; snap = '0;
        for (cyc = 2; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            v = {step_valid, in_addr, w_addr, out_addr, pad_zero, first, last};
            if (cyc == 2) check({name, ".valid_latency"}, step_valid, !exp_err);
            if (stalled) check($sformatf("%s.frozen@%0d", name, cyc), v, snap);
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({name, ".abort_zero"},
                      {step_valid, in_addr, w_addr, out_addr, pad_zero, first, last, busy, done, cfg_err}, 0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            start = poke && (cyc == 5);
            step_ready = !(drop_at > 0 && cyc >= drop_at && cyc < drop_at + 3);
            if (done) begin
                check({name, ".done_timing"}, cyc, exp_err ? 2 : last_acc + 1);
                check({name, ".busy_at_done"}, busy, 0);
                check({name, ".cfg_err"}, cfg_err, exp_err);
                finished = 1;
            end else if (step_valid && step_ready) begin
                obs.push_back(v[41:0]);
                nacc++;
                last_acc = cyc;
                if (exp_q.size() == 0) check({name, ".extra_step"}, nacc, exp_total);
                else check($sformatf("%s.step%0d", name, nacc - 1), v[41:0], exp_q.pop_front());
            end
            stalled = step_valid && !step_ready;
            snap = v;
        end
        start = 1'b0;
        step_ready = 1'b1;
        check({name, ".finished_in_budget"}, finished, 1);
        check({name, ".step_count"}, nacc, exp_total);
        @(negedge clk);
        check({name, ".done_one_cycle"}, done, 0);
    endtask

    initial begin
        int npz;
        rst = 1'b1; start = 1'b0; step_ready = 1'b1;
        set_cfg(0, 1, 1, 3, 3, 2, 2, 2, 1, 0);
        apply_cfg();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {step_valid, in_addr, w_addr, out_addr, pad_zero, first, last, busy, done, cfg_err}, 0);
        rst = 1'b0;

        // Basic walk
        set_cfg(0, 1, 1, 3, 3, 2, 2, 2, 1, 0);
        run("basic", 0, 0, 0, 0);
        check("basic.in0", obs[0][41:29], 1000);
        check("basic.in1", obs[1][41:29], 1001);
        check("basic.in2", obs[2][41:29], 1003);
        check("basic.in3", obs[3][41:29], 1004);
        check("basic.w3", obs[3][28:16], 2003);
        check("basic.last_out3", {obs[3][15:3], obs[3][0]}, {13'd3000, 1'b1});

        // Same walk with a 3-cycle ready drop and a start pulse while busy
        run("bp", 0, 6, 0, 1);

        // Padding
        set_cfg(0, 1, 1, 3, 3, 3, 3, 3, 1, 1);
        run("pad", 0, 0, 0, 0);
        npz = 0;
        for (int i = 0; i < 9; i++) npz += int'(obs[i][2]);
        check("pad.pix00_zero_count", npz, 5);
        check("pad.step5", {obs[4][41:29], obs[4][2]}, {13'd1000, 1'b0});

        // Stride
        set_cfg(0, 1, 1, 5, 5, 3, 2, 2, 2, 0);
        run("stride", 0, 0, 0, 0);
        check("stride.pix01", {obs[9][41:29], obs[9][15:3]}, {13'd1002, 13'd3001});
        check("stride.pix10", obs[18][41:29], 1010);

        // Depthwise
        set_cfg(1, 2, 2, 2, 2, 1, 2, 2, 1, 0);
        run("dw", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("dw.co1_%0d", i), {obs[4+i][41:29], obs[4+i][28:16], obs[4+i][15:3]},
                  {13'(1004 + i), 13'd2001, 13'(3004 + i)});

        // Configuration errors
        set_cfg(1, 2, 3, 2, 2, 1, 2, 2, 1, 0);
        run("dw_di_err", 1, 0, 0, 0);
        set_cfg(0, 1, 1, 3, 3, 2, 2, 2, 0, 0);
        run("stride0_err", 1, 0, 0, 0);

        // Abort mid-run, then a clean run from IDLE
        set_cfg(0, 1, 1, 3, 3, 2, 2, 2, 1, 0);
        run("abort", 0, 0, 6, 0);
        run("after_abort", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
